// File: rtl/ps2_keyboard_ctrl.sv
// ps2_keyboard_ctrl
//   Receives PS/2 bytes from the reader, brings the byte-valid level into the
//   clk domain, folds the E0/F0 prefix bytes into single key events and
//   queues the events in a FIFO that the CPU pops. When the FIFO is nearly
//   full, it asks the pad logic to inhibit the keyboard.
//
//   Optional feature macro: PS2_PREFIX_TIMEOUT_EN. When it is defined, a
//   partial prefix sequence is abandoned after TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_data    byte from the PS/2 reader
//   rx_update  reader byte-valid level (asynchronous)
//   ev_data    head event {brk, ext, code[7:0]}
//   ev_valid   FIFO non-empty
//   ev_ready   CPU pop request
//   count      FIFO occupancy 0..DEPTH
//   overflow   sticky flag, set when an event is dropped
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   ps2_hold   request to hold PS/2 clock low
//
// Decoder states
//   state    | meaning
//   IDLE     | no prefix pending
//   GOT_E0   | extended prefix seen
//   GOT_F0   | break prefix seen
//   GOT_E0F0 | extended break prefix seen
module ps2_keyboard_ctrl #(
   parameter int DEPTH          = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               rx_data,
   input  logic                     rx_update,
   output logic [9:0]               ev_data,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     ovf_clr,
   output logic                     ps2_hold
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] HOLD_CNT = (AW+1)'(DEPTH - 2);

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

   logic         sync1, sync2, sync3;
   logic         byte_strobe, byte_vld;
   logic [7:0]   byte_q;
   state_t       state, state_next;
   logic         push;
   logic [9:0]   ev_in;

   logic [9:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
   logic         do_pop, push_ok;
   logic [AW:0]  count_next;
   logic [9:0]   head_next;

   // two-flop synchronizer plus a delayed copy for rising-edge detection;
   // the strobe is registered, the byte is captured on the strobe cycle and
   // the decoder acts one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         sync3       <= 1'b0;
         byte_strobe <= 1'b0;
         byte_vld    <= 1'b0;
         byte_q      <= 8'h00;
      end else begin
         sync1       <= rx_update;
         sync2       <= sync1;
         sync3       <= sync2;
         byte_strobe <= sync2 & ~sync3;
         byte_vld    <= byte_strobe;
         if (byte_strobe) byte_q <= rx_data;
      end
   end

`ifdef PS2_PREFIX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmr;
   logic          timeout;

   // reloads on every decoded byte and while idle, so it only expires when
   // a prefix has been pending for TIMEOUT_CYCLES cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr <= TMR_LOAD;
      end else if (state == IDLE || byte_vld) begin
         tmr <= TMR_LOAD;
      end else if (tmr != '0) begin
         tmr <= tmr - TW'(1);
      end
   end
   assign timeout = (tmr == '0) && (state != IDLE);
`else
   logic timeout;
   assign timeout = 1'b0;
`endif

   // a decoded byte takes priority over an expiring timeout
   always_comb begin
      state_next = state;
      push       = 1'b0;
      ev_in      = '0;
      if (byte_vld) begin
         if (byte_q == 8'hE0) begin
            state_next = GOT_E0;
         end else if (byte_q == 8'hF0) begin
            state_next = (state == GOT_E0 || state == GOT_E0F0) ? GOT_E0F0 : GOT_F0;
         end else begin
            push       = 1'b1;
            ev_in      = {(state == GOT_F0 || state == GOT_E0F0),
                          (state == GOT_E0 || state == GOT_E0F0), byte_q};
            state_next = IDLE;
         end
      end else if (timeout) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // a full FIFO still accepts a push when the same edge pops
   assign do_pop  = ev_valid & ev_ready;
   assign push_ok = push & ((count != FULL_CNT) | do_pop);
   assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

   always_comb begin
      case ({push_ok, do_pop})
         2'b10:   count_next = count + (AW+1)'(1);
         2'b01:   count_next = count - (AW+1)'(1);
         default: count_next = count;
      endcase
   end

   // registered show-ahead head: bypass the incoming event when it lands in
   // the slot that becomes the head
   assign head_next = (push_ok && wr_ptr == rd_next) ? ev_in : mem[rd_next];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= ev_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ev_valid <= 1'b0;
         ev_data  <= '0;
         overflow <= 1'b0;
         ps2_hold <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         rd_ptr   <= rd_next;
         count    <= count_next;
         ev_valid <= (count_next != '0);
         if (count_next != '0) ev_data <= head_next;
         if (push && !push_ok) overflow <= 1'b1;
         else if (ovf_clr)     overflow <= 1'b0;
         ps2_hold <= (count >= HOLD_CNT);
      end
   end

endmodule

// File: doc/ps2_keyboard_ctrl.md
# ps2_keyboard_ctrl

Sequencing and buffering controller behind the PS/2 receive shifter. It brings the shifter's byte-complete strobe into the system clock domain and folds the `E0` and `F0` prefix bytes into single key events. Events are queued in a FIFO that the CPU pops, and the controller asks the keyboard to hold off when the FIFO nears full. It sits between the PS/2 reader and the CPU I/O port.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 4.
- `TIMEOUT_CYCLES`, 1000000: `clk` cycles of prefix inactivity before the decoder abandons a partial sequence. Used only with `PS2_PREFIX_TIMEOUT_EN`.
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: byte from the reader. Stable from before `rx_update` rises until well after it falls.
- `rx_update` in 1: reader's byte-valid level. Asynchronous (PS/2 clock domain); high for at least one PS/2 clock period.
- `ev_data` out 10: event `{brk, ext, code[7:0]}`.
- `ev_valid` out 1: FIFO non-empty; `ev_data` is the head entry.
- `ev_ready` in 1: CPU pop; an entry pops when `ev_valid && ev_ready` at a `clk` edge.
- `count` out log2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when an event is dropped.
- `ovf_clr` in 1: clears `overflow`.
- `ps2_hold` out 1: request to the pad logic to pull PS/2 clock low (inhibit the device).

## Operation
- **Synchronizer:** `rx_update` passes through 2 flip-flops, then a registered copy for rising-edge detection. Exactly one `byte_strobe` per rising edge. `rx_data` is captured into a byte register on the strobe cycle.
- **Decoder FSM:** states `IDLE`, `GOT_E0`, `GOT_F0`, `GOT_E0F0`. Acts only on the cycle after capture.
  - `IDLE`: `E0` → `GOT_E0`; `F0` → `GOT_F0`; any other byte → push `{0,0,byte}`, stay in `IDLE`.
  - `GOT_E0`: `F0` → `GOT_E0F0`; `E0` → stay in `GOT_E0`; other → push `{0,1,byte}`, go to `IDLE`.
  - `GOT_F0`: `E0` → `GOT_E0` (malformed sequence, restart); `F0` → stay in `GOT_F0`; other → push `{1,0,byte}`, go to `IDLE`.
  - `GOT_E0F0`: `E0` → `GOT_E0`; `F0` → stay in `GOT_E0F0`; other → push `{1,1,byte}`, go to `IDLE`.
  - All other bytes, including `E1`, `AA`, `FA` and `FE`, are emitted as ordinary codes; software handles them.
- **FIFO:** DEPTH×10 storage with registered show-ahead head. Pointers wrap modulo DEPTH; `count` has one extra bit to distinguish full from empty.
  - Push when full and no pop in the same cycle: event dropped, `overflow` ← 1, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, no overflow, `count` unchanged.
  - Push and pop in the same cycle when empty: only the push takes effect (head not yet valid).
  - Pop while empty: ignored.
- **Overflow flag:** `ovf_clr` and a new drop in the same cycle leave `overflow` = 1 (set wins).
- **Hold:** `ps2_hold` = registered (`count >= DEPTH-2`). This leaves margin for bytes already in flight.

## Timing
- Reset values: FSM `IDLE`, FIFO empty, `count` = 0, `ev_valid` = 0, `ev_data` = 0, `overflow` = 0, `ps2_hold` = 0, synchronizer flops 0.
- Let edge E be the first `clk` edge at which the first sync flop samples `rx_update` = 1.
  - `byte_strobe` is high in the cycle after E+2.
  - The FSM acts and the FIFO write occurs at edge E+4.
  - `ev_valid` is high after edge E+4 (empty FIFO case).
- Pop: `ev_data`/`ev_valid` reflect the next entry one cycle after the popping edge.
- `count` updates on the same edge as the push or pop.
- `ps2_hold` lags `count` by one cycle.
- Reset mid-sequence discards any partial prefix and all FIFO contents. A byte strobe in the reset cycle is lost.
- Back-to-back strobes: minimum strobe spacing is far above 4 cycles, so no strobe is lost in the pipeline.

## Configuration
- **`PS2_PREFIX_TIMEOUT_EN` defined:** a counter runs while the FSM is not in `IDLE` and restarts on every strobe.
  - On reaching `TIMEOUT_CYCLES`-1, the FSM returns to `IDLE` with no push.
  - A strobe in the same cycle as the timeout wins: it is decoded in the pre-timeout state.
- **Not defined:** no counter. The FSM waits indefinitely for the completing byte.

## Test plan
- **Plain make:** byte `1C` (A make) → one event `0x01C`; `ev_valid` at E+4; `count` = 1.
- **Extended break:** `E0, F0, 75` → exactly one event `0x375`; no events for the prefixes.
- **Overflow:** DEPTH=16, 17 bytes `01..11` with no pops → `count` = 16, `overflow` = 1, head `0x001`. `ps2_hold` rises one cycle after `count` = 14. Pulse `ovf_clr` → `overflow` = 0.
- **Full simultaneous push/pop:** `ev_ready` held high while full and a new byte arrives → `count` stays 16, `overflow` = 0, new event at the tail.
- **Reset mid-prefix:** `F0`, then `rst` for one cycle, then `1C` → event `0x01C` (no break flag), FIFO held only that event.
- **Timeout (`PS2_PREFIX_TIMEOUT_EN`, TIMEOUT_CYCLES=100):** `E0`, idle 200 cycles, then `1C` → event `0x01C`. Without the macro, the same stimulus → `0x11C`.
